hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/pipeline_hdrs_pkg.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 55 +++++
 rtl/hazard_unit.sv | 167 ++++++++++++++++
 tb/tb_hazard_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hdrs_pkg.sv
// Shared pipeline definitions for the hazard logic.
//   - RV32 major opcode constants used by decode
//   - sb_entry_t : one scoreboard slot {valid, rd, we, is_load}
//   - hz_state_e : hazard FSM states (RUN / FLUSH)
//   - decode_entry() : builds the scoreboard slot for an instruction
package pipeline_hdrs;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_e;

  // Stores and branches carry immediate bits in the rd field, so they never write.
  function automatic sb_entry_t decode_entry(input logic [6:0] op, input logic [4:0] rd);
    sb_entry_t e;
    e.valid   = 1'b1;
    e.rd      = rd;
    e.we      = !((op == OP_STORE) || (op == OP_BRANCH));
    e.is_load = (op == OP_LOAD);
    return e;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Producer scoreboard for the hazard unit.
// Holds FWD_STAGES in-flight producers; slot index i is pipeline stage k = i+1
// (slot 0 = EX/MEM, youngest). Everything shifts one slot per cycle and the
// oldest slot falls off the end.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_entry    : when push=1 slot 0 takes push_entry, else a bubble
//   rs1, rs2            : source register numbers of the decode instruction
//   use_rs1, use_rs2    : the corresponding source is actually read
//   match1, match2      : per-slot match of a live producer against rs1 / rs2
//   load_vec            : per-slot is_load flag
module hazard_scoreboard
  import pipeline_hdrs::*;
#(
  parameter int FWD_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  output logic [FWD_STAGES-1:0] match1,
  output logic [FWD_STAGES-1:0] match2,
  output logic [FWD_STAGES-1:0] load_vec
);

  sb_entry_t sb_q [FWD_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FWD_STAGES; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= push ? push_entry : '0;
      for (int i = 1; i < FWD_STAGES; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // x0 is never a real producer, so rd == 0 never matches.
  always_comb begin
    match1   = '0;
    match2   = '0;
    load_vec = '0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      match1[i]   = sb_q[i].valid && sb_q[i].we && (sb_q[i].rd != 5'd0) &&
                    use_rs1 && (sb_q[i].rd == rs1);
      match2[i]   = sb_q[i].valid && sb_q[i].we && (sb_q[i].rd != 5'd0) &&
                    use_rs2 && (sb_q[i].rd == rs2);
      load_vec[i] = sb_q[i].is_load;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall and
// control-flow flush.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   inst_f2d               : instruction currently in decode
//   inst_valid_f2d         : inst_f2d is a real instruction
//   br_taken               : a branch resolved taken this cycle
//   interrupt_sel          : interrupt redirect requested
//   stall                  : hold fetch/decode, insert a bubble
//   flush                  : kill fetch/decode contents
//   forward_ae, forward_be : operand source, 0 = regfile, k = stage k
//   fsm_state              : current flush FSM state (observability)
// Handshake: none; every output is a per-cycle combinational decision on the
// current decode instruction and the scoreboard. Flush dominates stall, and
// both force the forwarding selects to 0. All outputs are held at 0 while
// rst_n is low, independent of the clock.
module hazard_unit
  import pipeline_hdrs::*;
#(
  parameter int WIDTH        = 32,
  parameter int FWD_STAGES   = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                inst_f2d,
  input  logic                            inst_valid_f2d,
  input  logic                            br_taken,
  input  logic                            interrupt_sel,
  output logic                            stall,
  output logic                            flush,
  output logic [$clog2(FWD_STAGES+1)-1:0] forward_ae,
  output logic [$clog2(FWD_STAGES+1)-1:0] forward_be,
  output hz_state_e                       fsm_state
);

  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // ---------------- decode ----------------
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       use_rs1, use_rs2;
  logic       flush_req;
  logic       unused_inst_bits;

  assign opcode           = inst_f2d[6:0];
  assign rd               = inst_f2d[11:7];
  assign rs1              = inst_f2d[19:15];
  assign rs2              = inst_f2d[24:20];
  assign unused_inst_bits = ^{inst_f2d[WIDTH-1:25], inst_f2d[14:12]};

  // Sources of an invalid decode slot are never considered.
  assign use_rs1 = inst_valid_f2d &&
                   !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign use_rs2 = inst_valid_f2d &&
                   ((opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH));

  assign flush_req = br_taken || interrupt_sel ||
                     (inst_valid_f2d && ((opcode == OP_JALR) || (opcode == OP_JAL)));

  // ---------------- scoreboard ----------------
  logic [FWD_STAGES-1:0] match1, match2, load_vec;
  logic                  push;
  logic                  flush_raw;
  logic                  hazard;

  // Stalled or flushed instructions do not advance, so a bubble goes in.
  assign push = inst_valid_f2d && !stall && !flush;

  hazard_scoreboard #(
    .FWD_STAGES (FWD_STAGES)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (decode_entry(opcode, rd)),
    .rs1        (rs1),
    .rs2        (rs2),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .match1     (match1),
    .match2     (match2),
    .load_vec   (load_vec)
  );

  // ---------------- priority select ----------------
  // Scan oldest to youngest so the youngest match is the one left standing.
  logic [SEL_W-1:0] sel1, sel2;
  logic             ld_use1, ld_use2;

  always_comb begin
    sel1    = '0;
    sel2    = '0;
    ld_use1 = 1'b0;
    ld_use2 = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (match1[k-1]) begin
        sel1    = SEL_W'(k);
        ld_use1 = load_vec[k-1] && (k <= LOAD_LATENCY);
      end
      if (match2[k-1]) begin
        sel2    = SEL_W'(k);
        ld_use2 = load_vec[k-1] && (k <= LOAD_LATENCY);
      end
    end
  end

  assign hazard = ld_use1 || ld_use2;

  // ---------------- flush FSM ----------------
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // flush_cnt counts the flush cycles still owed after the current one.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_raw   = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (flush_req) begin
          flush_raw = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = HZ_FLUSH;
            flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      HZ_FLUSH: begin
        flush_raw = 1'b1;
        if (flush_req) begin
          flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_q == CNT_W'(1)) begin
          state_d     = HZ_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = HZ_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // ---------------- outputs ----------------
  // A load-use hazard coinciding with a flush is simply dropped.
  assign flush      = rst_n && flush_raw;
  assign stall      = rst_n && hazard && !flush_raw;
  assign forward_ae = (stall || flush || !rst_n) ? '0 : sel1;
  assign forward_be = (stall || flush || !rst_n) ? '0 : sel2;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import pipeline_hdrs::*;

  localparam int WIDTH        = 32;
  localparam int FWD_STAGES   = 2;
  localparam int LOAD_LATENCY = 1;
  localparam int FLUSH_CYCLES = 2;
  localparam int N_RANDOM     = 3000;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] inst_f2d;
  logic             inst_valid_f2d;
  logic             br_taken;
  logic             interrupt_sel;
  logic             stall;
  logic             flush;
  logic [1:0]       forward_ae;
  logic [1:0]       forward_be;
  hz_state_e        fsm_state;

  always #5 clk = ~clk;

  hazard_unit #(
    .WIDTH        (WIDTH),
    .FWD_STAGES   (FWD_STAGES),
    .LOAD_LATENCY (LOAD_LATENCY),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_f2d       (inst_f2d),
    .inst_valid_f2d (inst_valid_f2d),
    .br_taken       (br_taken),
    .interrupt_sel  (interrupt_sel),
    .stall          (stall),
    .flush          (flush),
    .forward_ae     (forward_ae),
    .forward_be     (forward_be),
    .fsm_state      (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2, input bit sub);
    return {(sub ? 7'h20 : 7'h00), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OP_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), ((op == OP_LOAD) ? 3'b010 : 3'b000), 5'(rd), op};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] inst, input logic v, input logic br, input logic intr);
    inst_f2d       = inst;
    inst_valid_f2d = v;
    br_taken       = br;
    interrupt_sel  = intr;
  endtask

  // Drive on the falling edge, sample 1 time unit later, well before the rising edge.
  task automatic step_check(input string tag, input logic [31:0] inst, input logic v,
                            input logic br, input logic intr, input logic e_st,
                            input logic e_fl, input logic [1:0] e_fa, input logic [1:0] e_fb);
    @(negedge clk);
    drive(inst, v, br, intr);
    #1;
    chk({tag, ".stall"}, 8'(stall), 8'(e_st));
    chk({tag, ".flush"}, 8'(flush), 8'(e_fl));
    chk({tag, ".fwd_a"}, 8'(forward_ae), 8'(e_fa));
    chk({tag, ".fwd_b"}, 8'(forward_be), 8'(e_fb));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] inst;
    logic        v, br, intr;
    logic        st, fl;
    logic [1:0]  fa, fb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] inst, input logic v, input logic br,
                              input logic intr, input logic st, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r.inst = inst; r.v = v; r.br = br; r.intr = intr;
    r.st = st; r.fl = fl; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // hist[k-1] is what decode handed on k cycles ago (bubble if nothing was accepted).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } prod_t;

  prod_t hist[$];
  int    flush_left;
  logic [5:0] exp_q[$];   // {stall, flush, fwd_a, fwd_b}

  task automatic model_reset();
    hist.delete();
    flush_left = 0;
  endtask

  // Returns youngest stage number producing reg r (0 = none) and whether it is a load.
  function automatic int youngest(input int r, output bit is_ld);
    is_ld = 0;
    for (int k = 1; k <= hist.size(); k++) begin
      if (hist[k-1].v && hist[k-1].we && hist[k-1].rd != 0 && hist[k-1].rd == r) begin
        is_ld = hist[k-1].ld;
        return k;
      end
    end
    return 0;
  endfunction

  task automatic model_cycle(input logic [31:0] inst, input logic v, input logic br,
                             input logic intr, output logic [5:0] exp);
    int  op, r1, r2, k1, k2, fa, fb;
    bit  u1, u2, l1, l2, haz, req, fl, st;
    prod_t rec;
    op  = int'(inst[6:0]);
    r1  = int'(inst[19:15]);
    r2  = int'(inst[24:20]);
    u1  = v && !(op == 'h37 || op == 'h17 || op == 'h6f);
    u2  = v && (op == 'h33 || op == 'h23 || op == 'h63);
    k1  = u1 ? youngest(r1, l1) : 0;
    k2  = u2 ? youngest(r2, l2) : 0;
    haz = (k1 != 0 && l1 && k1 <= LOAD_LATENCY) || (k2 != 0 && l2 && k2 <= LOAD_LATENCY);
    req = br || intr || (v && (op == 'h67 || op == 'h6f));
    fl  = req || (flush_left > 0);
    st  = haz && !fl;
    fa  = (st || fl) ? 0 : k1;
    fb  = (st || fl) ? 0 : k2;
    exp = {st, fl, 2'(fa), 2'(fb)};
    // advance to the next cycle
    rec.v  = v && !st && !fl;
    rec.rd = int'(inst[11:7]);
    rec.we = !(op == 'h23 || op == 'h63);
    rec.ld = (op == 'h03);
    if (!rec.v) begin rec.rd = 0; rec.we = 0; rec.ld = 0; end
    hist.push_front(rec);
    if (hist.size() > FWD_STAGES) void'(hist.pop_back());
    if (req) flush_left = FLUSH_CYCLES - 1;
    else if (flush_left > 0) flush_left--;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [6:0] op;
    ops[0] = OP_LOAD;  ops[1] = OP_OPIMM; ops[2] = OP_AUIPC; ops[3] = OP_STORE;
    ops[4] = OP_OP;    ops[5] = OP_LUI;   ops[6] = OP_BRANCH; ops[7] = OP_JALR;
    ops[8] = OP_JAL;   ops[9] = 7'h0b;
    // weight toward loads/ALU ops so hazards are frequent
    case ($urandom_range(0, 9))
      0, 1, 2: op = OP_LOAD;
      3, 4, 5: op = OP_OP;
      default: op = ops[$urandom_range(0, 9)];
    endcase
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 7)), op};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]  e, got;
    logic [31:0] ri;
    logic        rv, rb, rq;

    // Reset state, with flush-request inputs active to show outputs are gated.
    rst_n = 1'b0;
    drive(32'h0000_00ef, 1'b1, 1'b1, 1'b1);   // jal x1 + branch + interrupt
    #12;
    chk("rst.flush", 8'(flush), 8'd0);
    chk("rst.stall", 8'(stall), 8'd0);
    chk("rst.fwd_a", 8'(forward_ae), 8'd0);
    chk("rst.fwd_b", 8'(forward_be), 8'd0);
    chk("rst.state", 8'(fsm_state), 8'(HZ_RUN));
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Directed vectors (inst, valid, br, intr | stall, flush, fwd_a, fwd_b)
    tbl.push_back(mk(enc_r(5, 1, 2, 0),         1, 0, 0, 0, 0, 0, 0)); // add x5,x1,x2
    tbl.push_back(mk(enc_r(6, 5, 3, 0),         1, 0, 0, 0, 0, 1, 0)); // add x6,x5,x3
    tbl.push_back(mk(enc_r(5, 1, 2, 0),         1, 0, 0, 0, 0, 0, 0)); // add x5,x1,x2
    tbl.push_back(mk(32'h0000_0013,             1, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(enc_r(7, 4, 5, 1),         1, 0, 0, 0, 0, 0, 2)); // sub x7,x4,x5
    tbl.push_back(mk(enc_i(OP_LOAD, 5, 1, 0),   1, 0, 0, 0, 0, 0, 0)); // lw x5,0(x1)
    tbl.push_back(mk(enc_r(7, 5, 5, 0),         1, 0, 0, 1, 0, 0, 0)); // add x7,x5,x5 stalls
    tbl.push_back(mk(enc_r(7, 5, 5, 0),         1, 0, 0, 0, 0, 2, 2)); // released
    tbl.push_back(mk(enc_i(OP_OPIMM, 0, 1, 1),  1, 0, 0, 0, 0, 0, 0)); // addi x0,x1,1
    tbl.push_back(mk(enc_r(2, 0, 0, 0),         1, 0, 0, 0, 0, 0, 0)); // add x2,x0,x0
    tbl.push_back(mk(enc_i(OP_OPIMM, 5, 0, 1),  1, 0, 0, 0, 0, 0, 0)); // addi x5,x0,1
    tbl.push_back(mk(enc_i(OP_OPIMM, 5, 0, 2),  1, 0, 0, 0, 0, 0, 0)); // addi x5,x0,2
    tbl.push_back(mk(enc_r(8, 5, 0, 0),         1, 0, 0, 0, 0, 1, 0)); // youngest x5 wins
    tbl.push_back(mk(enc_i(OP_LOAD, 9, 1, 0),   1, 0, 0, 0, 0, 0, 0)); // lw x9
    tbl.push_back(mk(enc_r(10, 9, 9, 0),        1, 1, 0, 0, 1, 0, 0)); // use + br_taken
    tbl.push_back(mk(enc_r(10, 9, 9, 0),        1, 0, 0, 0, 1, 0, 0)); // 2nd flush cycle
    tbl.push_back(mk(32'h0,                     0, 0, 0, 0, 0, 0, 0)); // flush over
    tbl.push_back(mk(32'h0000_00ef,             1, 0, 0, 0, 1, 0, 0)); // jal x1
    tbl.push_back(mk(32'h0,                     0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(32'h0,                     0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(32'h0,                     0, 0, 1, 0, 1, 0, 0)); // interrupt
    tbl.push_back(mk(enc_i(OP_JALR, 0, 1, 0),   1, 0, 0, 0, 1, 0, 0)); // jalr reloads
    tbl.push_back(mk(32'h0,                     0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(32'h0,                     0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(enc_i(OP_LOAD, 5, 1, 0),   1, 0, 0, 0, 0, 0, 0)); // lw x5
    tbl.push_back(mk(enc_r(7, 5, 5, 0),         0, 0, 0, 0, 0, 0, 0)); // invalid use
    tbl.push_back(mk(enc_r(7, 5, 5, 0),         1, 0, 0, 0, 0, 2, 2)); // load now at stage 2

    foreach (tbl[i]) begin
      step_check($sformatf("vec%0d", i), tbl[i].inst, tbl[i].v, tbl[i].br, tbl[i].intr,
                 tbl[i].st, tbl[i].fl, tbl[i].fa, tbl[i].fb);
    end

    // Reset during the second flush cycle.
    step_check("rf.c1", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step_check("rf.c2", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("rf.async_flush", 8'(flush), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step_check($sformatf("rf.post%0d", i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Reset during a load-use stall.
    step_check("rs.lw",  enc_i(OP_LOAD, 5, 1, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step_check("rs.use", enc_r(7, 5, 5, 0),       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("rs.async_stall", 8'(stall), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_check("rs.post", enc_r(7, 5, 5, 0),      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Randomized traffic against the reference model, from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < N_RANDOM; n++) begin
      @(negedge clk);
      ri = rand_inst();
      rv = ($urandom_range(0, 9) < 8);
      rb = ($urandom_range(0, 19) == 0);
      rq = ($urandom_range(0, 39) == 0);
      drive(ri, rv, rb, rq);
      model_cycle(ri, rv, rb, rq, e);
      exp_q.push_back(e);
      #1;
      got = {stall, flush, forward_ae, forward_be};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rand%0d inst=%h v=%0b br=%0b irq=%0b: got st/fl/fa/fb=%0b/%0b/%0d/%0d expected %0b/%0b/%0d/%0d",
                 n, ri, rv, rb, rq, got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
